pkt_fetch: RTL and testbench

- Initiator side of the packet RAM read port: walks word-aligned byte addresses, absorbs the RAM's 1-cycle registered read latency, and streams the packet words downstream on a valid/ready interface with a last flag.
- Sits between a packet-RAM instance and the switch parser pipeline.
- Software or a control block launches a transfer with a start pulse, a base byte address and a word count.

---
 rtl/pkt_fetch_pkg.sv | 33 +++
 rtl/pkt_fetch_fifo2.sv | 73 +++++++
 rtl/pkt_fetch.sv | 217 +++++++++++++++++++++
 tb/tb_pkt_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_fetch_pkg.sv
// pkt_fetch_pkg: shared definitions for the packet-RAM fetch engine.
//   - Default widths for the byte address, data word and word count.
//   - ZERO_WORD constant used for cleared data paths.
//   - FSM state encoding (IDLE=0, FETCH=1, DONE=2).
//   - credit_ok(): read-issue credit rule shared by the top level.
// No ports (package).
package pkt_fetch_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 7;

    localparam logic [DATA_WIDTH_DEF-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // At most two words may be issued but not yet accepted downstream
    // (one in the RAM pipeline plus buffered words). A pop in the same
    // cycle frees one slot, which is what allows one word per cycle.
    //   outstanding = rd_vld + fifo_count, with fifo_count in 0..2
    //   outstanding < 2  <=>  !full && !(rd_vld && !empty)
    function automatic logic credit_ok(input logic rd_vld,
                                       input logic fifo_full,
                                       input logic fifo_empty,
                                       input logic pop);
        return pop || (!fifo_full && !(rd_vld && !fifo_empty));
    endfunction

endpackage

// File: rtl/pkt_fetch_fifo2.sv
// pkt_fetch_fifo2: 2-entry FIFO carrying a data word plus a last flag.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push_i              write push_data_i/push_last_i (accepted when not
//                       full, or when full together with a pop)
//   push_data_i         word to store
//   push_last_i         last flag to store with the word
//   pop_i               remove the head entry (ignored when empty)
//   pop_data_o          head word
//   pop_last_o          head last flag
//   full_o, empty_o     occupancy flags
module pkt_fetch_fifo2
    import pkt_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_last_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic [1:0]            last_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

    // A push into a full FIFO is legal only alongside a pop: the slot being
    // written is the head being read out in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = data_q[rd_ptr_q];
    assign pop_last_o = last_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pkt_fetch.sv
// pkt_fetch: read initiator for the packet RAM. Walks word-aligned byte
// addresses, absorbs the RAM's one-cycle registered read latency and streams
// the words downstream on a valid/ready interface with a last flag.
//
// Optional feature: define PKT_FETCH_CHECKSUM_EN to build a running XOR of
// all accepted words on csum_o; otherwise csum_o is tied to zero.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_i         launch pulse, sampled only in IDLE
//   base_addr_i     first byte address (bits [1:0] forced to 0)
//   len_i           number of words to fetch (0 allowed)
//   busy_o          high in FETCH and DONE
//   done_o          one-cycle pulse after the last word is accepted
//   mem_addr_o      byte address to the RAM (holds when not issuing)
//   mem_data_i      RAM read data, valid the cycle after the address
//   out_data_o      streamed word (zero when out_valid_o is low)
//   out_valid_o     out_data_o valid
//   out_last_o      final word of the transfer
//   out_ready_i     downstream ready
//   csum_o          XOR checksum of the accepted words
//   dbg_state_o     current FSM state, for debug/observation
//
// Handshake: a word moves when out_valid_o && out_ready_i in the same cycle.
// Once out_valid_o rises it stays high, with out_data_o/out_last_o stable,
// until that transfer happens.
module pkt_fetch
    import pkt_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] csum_o,
    output state_e                dbg_state_o
);

    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [LEN_WIDTH-1:0]  ONE        = LEN_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;  // address of the next issue
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;  // most recently issued address
    logic [LEN_WIDTH-1:0]  issue_rem_q, issue_rem_d;  // reads still to issue
    logic [LEN_WIDTH-1:0]  acc_rem_q, acc_rem_d;      // words still to be accepted
    logic                  rd_vld_q, rd_vld_d;        // mem_data_i carries a word this cycle
    logic                  rd_last_q, rd_last_d;      // ... and it is the final one

    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH-1:0] base_aligned;
    logic                  start_acc;
    logic                  pop;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_last;

    assign base_aligned = base_addr_i & ALIGN_MASK;

    pkt_fetch_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_vld_q),
        .push_data_i (mem_data_i),
        .push_last_i (rd_last_q),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .pop_last_o  (fifo_last),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = out_valid_o ? fifo_data : DATA_WIDTH'(ZERO_WORD);
    assign out_last_o  = out_valid_o && fifo_last;

    assign busy_o      = (state_q == ST_FETCH) || (state_q == ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

    // The address is driven straight from the issue decision so the first
    // read goes out in the start cycle; between issues the last issued
    // address is held.
    assign mem_addr_o = issue ? issue_addr : last_addr_q;

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        last_addr_d = last_addr_q;
        issue_rem_d = issue_rem_q;
        acc_rem_d   = acc_rem_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        issue_addr  = next_addr_q;
        start_acc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_acc  = 1'b1;
                    acc_rem_d  = len_i;
                    issue_addr = base_aligned;
                    // A zero-length transfer still spends one cycle in FETCH,
                    // so done_o lands two cycles after the start pulse.
                    state_d    = ST_FETCH;
                    if (len_i != '0) begin
                        issue       = 1'b1;
                        issue_last  = (len_i == ONE);
                        issue_rem_d = len_i - ONE;
                        next_addr_d = base_aligned + WORD_BYTES;
                    end else begin
                        issue_rem_d = '0;
                        next_addr_d = base_aligned;
                    end
                end
            end
            ST_FETCH: begin
                if ((issue_rem_q != '0) &&
                    credit_ok(rd_vld_q, fifo_full, fifo_empty, pop)) begin
                    issue       = 1'b1;
                    issue_last  = (issue_rem_q == ONE);
                    issue_addr  = next_addr_q;
                    issue_rem_d = issue_rem_q - ONE;
                    next_addr_d = next_addr_q + WORD_BYTES;  // wraps modulo 2^ADDR_WIDTH
                end
                if (pop) begin
                    acc_rem_d = acc_rem_q - ONE;
                end
                if ((acc_rem_q == '0) || (pop && (acc_rem_q == ONE))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            last_addr_d = issue_addr;
        end
        rd_vld_d  = issue;
        rd_last_d = issue_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            next_addr_q <= '0;
            last_addr_q <= '0;
            issue_rem_q <= '0;
            acc_rem_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            last_addr_q <= last_addr_d;
            issue_rem_q <= issue_rem_d;
            acc_rem_q   <= acc_rem_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
        end
    end

`ifdef PKT_FETCH_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    // Cleared on an accepted start; after the last accept nothing pops, so
    // the final value holds through DONE and IDLE until the next start.
    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = DATA_WIDTH'(ZERO_WORD);
        end else if (pop) begin
            csum_d = csum_q ^ fifo_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= DATA_WIDTH'(ZERO_WORD);
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign csum_o           = DATA_WIDTH'(ZERO_WORD);
`endif

endmodule

// File: tb/tb_pkt_fetch.sv
// tb_pkt_fetch: directed, table-driven bench for pkt_fetch. A 64-word
// registered-read RAM model holds word k = k + 0x100. Each table record gives
// a transfer (base, length, repeating ready pattern) with hand-computed first
// word and checksum; the stream is scored against an expected queue. A
// hand-written sequence covers reset in the middle of a transfer.
module tb_pkt_fetch;
    import pkt_fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [6:0]  len_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_last_o;
    logic        out_ready_i;
    logic [31:0] csum_o;
    state_e      dbg_state_o;

    logic [31:0] ram [64];
    logic [31:0] exp_q [$];

    int n_vec;
    int n_bad;

    typedef struct {
        logic [31:0] base;
        int          len;
        logic [7:0]  rpat;       // ready bit for cycle c is rpat[c % rlen]
        int          rlen;
        logic [31:0] first_word;
        logic [31:0] csum;
        bit          poke;       // pulse start_i mid-transfer (must be ignored)
    } vec_t;

    vec_t vecs [7];

    pkt_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .csum_o      (csum_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM: address in cycle N, data in cycle N+1.
    always @(posedge clk) mem_data_i <= ram[mem_addr_o[7:2]];

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] hand);
`ifdef PKT_FETCH_CHECKSUM_EN
        return hand;
`else
        return (hand & 32'h0);
`endif
    endfunction

    // ---------------- driver + monitor for one transfer ----------------
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr_q [$];
        logic [31:0] saved_d;
        logic        saved_l;
        logic [31:0] csum_done;
        logic [31:0] cs_exp;
        bit          stall;
        bit          done_seen;
        int          issues;
        int          acc;
        int          first_c;
        int          last_acc_c;
        int          done_c;
        int          max_out;
        int          busy_bad;
        int          exp_done_c;

        exp_q.delete();
        for (int i = 0; i < v.len; i++) begin
            exp_q.push_back(32'h100 + ((v.first_word - 32'h100 + 32'(i)) & 32'h3F));
            exp_addr_q.push_back((v.base & ~32'h3) + 32'(4 * i));
        end
        cs_exp     = exp_csum(v.csum);
        stall      = 1'b0;
        done_seen  = 1'b0;
        issues     = 0;
        acc        = 0;
        first_c    = -1;
        last_acc_c = -1;
        done_c     = -1;
        max_out    = 0;
        busy_bad   = 0;
        saved_d    = '0;
        saved_l    = 1'b0;
        csum_done  = '0;

        for (int c = 0; c < 200 && !done_seen; c++) begin
            @(negedge clk);
            start_i     = (c == 0) || (v.poke && c == 3);
            base_addr_i = (c == 0) ? v.base : 32'h80;
            len_i       = (c == 0) ? 7'(v.len) : 7'd3;
            out_ready_i = v.rpat[c % v.rlen];
            #1;
            if (exp_addr_q.size() > 0 && mem_addr_o == exp_addr_q[0]) begin
                void'(exp_addr_q.pop_front());
                issues++;
            end
            if (busy_o !== (c >= 1)) busy_bad++;
            if (stall) begin
                chk("stall_valid_held", out_valid_o, 1'b1);
                chk("stall_data_stable", out_data_o, saved_d);
                chk("stall_last_stable", out_last_o, saved_l);
            end
            stall = 1'b0;
            if (out_valid_o) begin
                if (first_c < 0) first_c = c;
                if (out_ready_i) begin
                    if (exp_q.size() > 0) chk("word_data", out_data_o, exp_q.pop_front());
                    else                  chk("word_extra", out_data_o, 32'hDEAD_BEEF);
                    chk("word_last", out_last_o, (acc == v.len - 1));
                    acc++;
                    last_acc_c = c;
                end else begin
                    stall   = 1'b1;
                    saved_d = out_data_o;
                    saved_l = out_last_o;
                end
            end
            if (issues - acc > max_out) max_out = issues - acc;
            if (done_o) begin
                done_seen = 1'b1;
                done_c    = c;
                csum_done = csum_o;
            end
        end

        exp_done_c = (v.len == 0) ? 2 : last_acc_c + 1;
        chk("done_seen", done_seen, 1'b1);
        chk("words_accepted", acc, v.len);
        chk("reads_issued", issues, v.len);
        chk("outstanding_le2", (max_out <= 2), 1'b1);
        chk("first_valid_cycle", first_c, (v.len == 0) ? -1 : 2);
        chk("done_cycle", done_c, exp_done_c);
        chk("busy_window", busy_bad, 0);
        if (v.rlen == 1 && v.len > 0) chk("full_rate", last_acc_c - first_c, v.len - 1);
        chk("csum_at_done", csum_done, cs_exp);

        @(negedge clk);
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk("done_single_pulse", done_o, 1'b0);
        chk("busy_after_done", busy_o, 1'b0);
        chk("csum_hold", csum_o, cs_exp);
        chk("state_idle", dbg_state_o, ST_IDLE);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int done_bad;

        n_vec = 0;
        n_bad = 0;
        for (int k = 0; k < 64; k++) ram[k] = 32'h100 + 32'(k);

        //           base      len rpat   rlen first     csum      poke
        vecs[0] = '{32'h0000_0000, 4, 8'h01, 1, 32'h100, 32'h000, 1'b0};
        vecs[1] = '{32'h0000_000B, 2, 8'h01, 1, 32'h102, 32'h001, 1'b0};
        vecs[2] = '{32'h0000_0010, 8, 8'h29, 6, 32'h104, 32'h000, 1'b1};
        vecs[3] = '{32'h0000_0040, 0, 8'h01, 1, 32'h100, 32'h000, 1'b0};
        vecs[4] = '{32'h0000_001C, 3, 8'h01, 1, 32'h107, 32'h106, 1'b0};
        vecs[5] = '{32'h0000_00F4, 5, 8'h02, 2, 32'h13D, 32'h13D, 1'b0};
        vecs[6] = '{32'h0000_0004, 1, 8'h04, 3, 32'h101, 32'h101, 1'b0};

        rst         = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        len_i       = '0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", dbg_state_o, ST_IDLE);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_valid", out_valid_o, 1'b0);
        chk("reset_addr", mem_addr_o, 32'h0);
        chk("reset_csum", csum_o, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of an 8-word transfer after three accepts.
        acc = 0;
        for (int c = 0; c < 30 && acc < 3; c++) begin
            @(negedge clk);
            start_i     = (c == 0);
            base_addr_i = 32'h0;
            len_i       = 7'd8;
            out_ready_i = 1'b1;
            #1;
            if (out_valid_o && out_ready_i) acc++;
        end
        chk("pre_reset_words", acc, 3);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        chk("midrst_valid", out_valid_o, 1'b0);
        chk("midrst_data", out_data_o, 32'h0);
        chk("midrst_last", out_last_o, 1'b0);
        chk("midrst_addr", mem_addr_o, 32'h0);
        chk("midrst_csum", csum_o, 32'h0);
        chk("midrst_state", dbg_state_o, ST_IDLE);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        done_bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (done_o || busy_o || out_valid_o) done_bad++;
        end
        chk("no_done_after_abort", done_bad, 0);

        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
